// File: rtl/int_fp_pkg.sv
// Shared definitions for the INT16/FP16 MAC adder stage: operand width, mode
// encodings, accumulator FSM states and small FP16 field helpers.
package int_fp_pkg;

    localparam int DATA_W = 16;

    localparam logic MODE_INT = 1'b0;
    localparam logic MODE_FP  = 1'b1;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic fp16_is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    function automatic logic fp16_is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    endfunction

    // Subnormals share the exponent of the smallest normal (1) with no hidden bit.
    function automatic logic [5:0] fp16_eff_exp(input logic [4:0] e);
        return (e == 5'd0) ? 6'd1 : {1'b0, e};
    endfunction

    function automatic logic [10:0] fp16_mant(input logic [15:0] x);
        return {(x[14:10] != 5'd0), x[9:0]};
    endfunction

endpackage

// File: rtl/int_fp_add.sv
// Combinational adder: INT16 wrapping add or FP16 add with round-to-nearest-even,
// subnormal support, overflow to infinity and a canonical quiet NaN.
module int_fp_add
    import int_fp_pkg::*;
(
    input  logic              mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    logic [15:0] int_sum_s;
    logic [15:0] fp_sum_s;
    logic [15:0] big_s;
    logic [15:0] sml_s;
    logic        eff_sub_s;
    logic [5:0]  big_exp_s;
    logic [5:0]  sml_exp_s;
    logic [5:0]  exp_diff_s;
    logic [13:0] big_man_s;
    logic [13:0] sml_man_s;
    logic [13:0] sml_sh_s;
    logic [13:0] sml_al_s;
    logic        sticky_s;
    logic [14:0] raw_s;
    logic [13:0] norm_s;
    logic [5:0]  norm_exp_s;
    logic        inc_s;
    logic [11:0] rnd_s;
    logic [5:0]  fin_exp_s;
    logic [9:0]  fin_frac_s;

    assign int_sum_s = a + b;

    // Order operands by magnitude so the aligned subtraction never goes negative.
    always_comb begin
        if (b[14:0] > a[14:0]) begin
            big_s = b;
            sml_s = a;
        end else begin
            big_s = a;
            sml_s = b;
        end
    end

    assign eff_sub_s  = big_s[15] ^ sml_s[15];
    assign big_exp_s  = fp16_eff_exp(big_s[14:10]);
    assign sml_exp_s  = fp16_eff_exp(sml_s[14:10]);
    assign exp_diff_s = big_exp_s - sml_exp_s;
    // Three extra low bits hold guard, round and a folded sticky bit.
    assign big_man_s  = {fp16_mant(big_s), 3'b000};
    assign sml_man_s  = {fp16_mant(sml_s), 3'b000};
    assign sml_sh_s   = sml_man_s >> exp_diff_s;
    assign sticky_s   = |(sml_man_s & ~(14'h3FFF << exp_diff_s));
    assign sml_al_s   = {sml_sh_s[13:1], sml_sh_s[0] | sticky_s};
    assign raw_s      = eff_sub_s ? ({1'b0, big_man_s} - {1'b0, sml_al_s})
                                  : ({1'b0, big_man_s} + {1'b0, sml_al_s});

    // Normalise: right by one on carry-out, else left until the hidden bit or exponent 1.
    always_comb begin
        norm_s     = raw_s[13:0];
        norm_exp_s = big_exp_s;
        if (raw_s[14]) begin
            norm_s     = {raw_s[14:2], raw_s[1] | raw_s[0]};
            norm_exp_s = big_exp_s + 6'd1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!norm_s[13] && (norm_exp_s > 6'd1)) begin
                    norm_s     = {norm_s[12:0], 1'b0};
                    norm_exp_s = norm_exp_s - 6'd1;
                end else begin
                    norm_s     = norm_s;
                    norm_exp_s = norm_exp_s;
                end
            end
        end
    end

    // Round to nearest even and pack, saturating the exponent into infinity.
    always_comb begin
        inc_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        rnd_s = {1'b0, norm_s[13:3]} + {11'd0, inc_s};
        if (rnd_s[11]) begin
            fin_exp_s  = norm_exp_s + 6'd1;
            fin_frac_s = 10'd0;
        end else if (rnd_s[10]) begin
            fin_exp_s  = norm_exp_s;
            fin_frac_s = rnd_s[9:0];
        end else begin
            fin_exp_s  = 6'd0;
            fin_frac_s = rnd_s[9:0];
        end
        if (raw_s == 15'd0) begin
            fp_sum_s = {big_s[15] & ~eff_sub_s, 15'd0};
        end else if (fin_exp_s >= 6'd31) begin
            fp_sum_s = {big_s[15], 15'h7C00};
        end else begin
            fp_sum_s = {big_s[15], fin_exp_s[4:0], fin_frac_s};
        end
    end

    // Select the integer result or the FP result with special operands applied.
    always_comb begin
        if (mode == MODE_INT) begin
            sum = int_sum_s;
        end else if (fp16_is_nan(a) || fp16_is_nan(b) ||
                     (fp16_is_inf(a) && fp16_is_inf(b) && (a[15] != b[15]))) begin
            sum = FP16_QNAN;
        end else if (fp16_is_inf(a)) begin
            sum = a;
        end else if (fp16_is_inf(b)) begin
            sum = b;
        end else begin
            sum = fp_sum_s;
        end
    end

endmodule

// File: rtl/int_fp_acc.sv
// Frame accumulator: sums a valid/ready stream of INT16 or FP16 products and
// presents one registered result per frame on an output valid/ready handshake.
module int_fp_acc #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy
);
    import int_fp_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] out_data_r;
    logic [DATA_W-1:0] sum_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  out_count_r;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              mode_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              accept_s;

    assign accept_s  = in_valid && in_ready_r;
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    int_fp_add u_add (
        .mode (mode_r),
        .a    (acc_r),
        .b    (in_data),
        .sum  (sum_s)
    );

    // Frame FSM with accumulator, beat counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_r     <= ST_IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            mode_r      <= MODE_INT;
            out_data_r  <= '0;
            out_count_r <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r  <= in_data;
                        mode_r <= mode;
                        cnt_r  <= CNT_ONE;
                        busy_r <= 1'b1;
                        if (in_last) begin
                            state_r     <= ST_DONE;
                            out_data_r  <= in_data;
                            out_count_r <= CNT_ONE;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                        end else begin
                            state_r <= ST_ACC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (accept_s) begin
                        acc_r <= sum_s;
                        cnt_r <= cnt_inc_s;
                        if (in_last) begin
                            state_r     <= ST_DONE;
                            out_data_r  <= sum_s;
                            out_count_r <= cnt_inc_s;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                        end else begin
                            state_r <= ST_ACC;
                        end
                    end else begin
                        state_r <= ST_ACC;
                    end
                end
                ST_DONE: begin
                    // Result accepted: return to idle; no beat is taken this cycle.
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        acc_r       <= '0;
                        cnt_r       <= '0;
                        out_data_r  <= '0;
                        out_count_r <= '0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    acc_r       <= '0;
                    cnt_r       <= '0;
                    out_data_r  <= '0;
                    out_count_r <= '0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_count = out_count_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_int_fp_acc.sv
// Self-checking bench for int_fp_acc: directed frames with literal expectations plus
// randomized frames compared every cycle against a real-arithmetic reference model.
module tb_int_fp_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Reference model: a frame is open, a result is pending, the running sum and count.
    bit          m_open = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_mode = 1'b0;
    logic [15:0] m_acc = 16'd0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    int_fp_acc #(.DATA_W(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real f2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) v = real'(int'(h[9:0])) * pow2(-24);
        else v = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -v : v;
    endfunction

    // Exact real sum of the operands rounded to the nearest FP16, ties to even.
    function automatic logic [15:0] fp_add_model(input logic [15:0] a, input logic [15:0] b);
        bit     an, bn, ai, bi, sg;
        real    s, v, n;
        int     e;
        longint t, ip, fr, half;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        if (an || bn || (ai && bi && (a[15] != b[15]))) return 16'h7E00;
        if (ai) return a;
        if (bi) return b;
        s = f2r(a) + f2r(b);
        if (s == 0.0) return {a[15] & b[15], 15'd0};
        sg = (s < 0.0);
        v = sg ? -s : s;
        e = 16;
        while (e > -14 && v < pow2(e)) e--;
        n = v / pow2(e - 10);
        t = longint'(n * pow2(30));
        ip = t >>> 30;
        fr = t - (ip <<< 30);
        half = longint'(1) <<< 29;
        if (fr > half || (fr == half && ip[0])) ip++;
        if (ip == longint'(2048)) begin
            ip = 1024;
            e++;
        end
        if (e > 15) return {sg, 15'h7C00};
        if (ip >= longint'(1024)) return {sg, 5'(e + 15), 10'(ip - 1024)};
        return {sg, 5'd0, 10'(ip)};
    endfunction

    function automatic logic [15:0] add_model(input bit m, input logic [15:0] a, input logic [15:0] b);
        if (m) return fp_add_model(a, b);
        return 16'((int'(a) + int'(b)) % 65536);
    endfunction

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_update();
        if (!rst_n || clear) begin
            m_open = 1'b0;
            m_pend = 1'b0;
            m_acc  = 16'd0;
            m_cnt  = 0;
        end else if (m_pend) begin
            if (out_ready) m_pend = 1'b0;
        end else if (in_valid) begin
            if (!m_open) begin
                m_acc  = in_data;
                m_mode = mode;
                m_cnt  = 1;
            end else begin
                m_acc = add_model(m_mode, m_acc, in_data);
                m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            end
            m_open = !in_last;
            m_pend = in_last;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("in_ready", in_ready, m_pend ? 32'd0 : 32'd1);
        chk("out_valid", out_valid, m_pend ? 32'd1 : 32'd0);
        chk("busy", busy, (m_open || m_pend) ? 32'd1 : 32'd0);
        if (m_pend) begin
            chk("out_data", out_data, m_acc);
            chk("out_count", out_count, m_cnt);
        end
    endtask

    task automatic beat(input bit m, input logic [15:0] d, input bit last);
        in_valid = 1'b1;
        mode     = m;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic logic [15:0] gen_data(input bit m);
        int r;
        r = $urandom_range(0, 9);
        if (!m || r == 0) return 16'($urandom);
        if (r == 1) return {1'($urandom), 5'd0, 10'($urandom)};
        return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
    endfunction

    initial begin
        // Reset state
        step();
        step();
        rst_n = 1'b1;
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_count", out_count, 32'h0);
        chk("reset_in_ready", in_ready, 32'h1);
        step();

        // Model pinned to hand-computed FP16 sums
        chk("model_fp_1p2", fp_add_model(16'h3C00, 16'h4000), 32'h4200);
        chk("model_fp_inf", fp_add_model(16'h7BFF, 16'h7BFF), 32'h7C00);
        chk("model_fp_cancel", fp_add_model(16'h3C00, 16'hBC00), 32'h0000);

        // INT frame; result valid right after the last beat
        beat(1'b0, 16'h0005, 1'b0);
        beat(1'b0, 16'h0007, 1'b0);
        beat(1'b0, 16'hFFFE, 1'b1);
        chk("t1_valid", out_valid, 32'h1);
        chk("t1_data", out_data, 32'h000A);
        chk("t1_count", out_count, 32'h3);
        // Backpressure: result held, beats offered are refused
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
            in_last  = 1'b1;
            step();
            chk("t4_ready_low", in_ready, 32'h0);
            chk("t4_data_hold", out_data, 32'h000A);
            chk("t4_count_hold", out_count, 32'h3);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        accept_result();
        chk("t4_release_valid", out_valid, 32'h0);
        chk("t4_release_ready", in_ready, 32'h1);

        // FP16 frame: 1.0 + 2.0 + 0.5
        beat(1'b1, 16'h3C00, 1'b0);
        beat(1'b1, 16'h4000, 1'b0);
        beat(1'b1, 16'h3800, 1'b1);
        chk("t2_data", out_data, 32'h4300);
        chk("t2_count", out_count, 32'h3);
        accept_result();

        // Single FP16 beat is loaded without an add
        beat(1'b1, 16'hC500, 1'b1);
        chk("t3_data", out_data, 32'hC500);
        chk("t3_count", out_count, 32'h1);
        accept_result();

        // INT wrap with mode toggled mid-frame
        beat(1'b0, 16'h7FFF, 1'b0);
        beat(1'b1, 16'h0001, 1'b1);
        chk("t5_data", out_data, 32'h8000);
        accept_result();

        // Clear beats a simultaneous last beat, then a fresh frame
        beat(1'b0, 16'h0100, 1'b0);
        beat(1'b0, 16'h0200, 1'b0);
        clear = 1'b1;
        beat(1'b0, 16'h0300, 1'b1);
        clear = 1'b0;
        chk("t6_clear_valid", out_valid, 32'h0);
        beat(1'b0, 16'h0001, 1'b0);
        beat(1'b0, 16'h0001, 1'b1);
        chk("t6_data", out_data, 32'h0002);
        chk("t6_count", out_count, 32'h2);
        accept_result();

        // Reset mid-frame
        beat(1'b0, 16'h0042, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_rst_valid", out_valid, 32'h0);
        chk("t6_rst_ready", in_ready, 32'h1);
        chk("t6_rst_busy", busy, 32'h0);

        // Counter saturation over a long frame
        for (int i = 0; i < 299; i++) beat(1'b0, 16'h0001, 1'b0);
        beat(1'b0, 16'h0001, 1'b1);
        chk("sat_count", out_count, 32'hFF);
        chk("sat_data", out_data, 32'h012C);
        accept_result();

        // Randomized frames with gaps, backpressure, mode toggles and occasional clears
        for (int f = 0; f < 150; f++) begin
            bit fm;
            int len;
            fm  = 1'($urandom);
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) step();
                if ($urandom_range(0, 40) == 0) clear = 1'b1;
                beat((k == 0) ? fm : 1'($urandom), gen_data(fm), k == len - 1);
                clear = 1'b0;
            end
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                in_valid = 1'($urandom);
                in_data  = 16'($urandom);
                in_last  = 1'($urandom);
                step();
            end
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            in_last   = 1'b1;
            accept_result();
            in_valid  = 1'b0;
            in_last   = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
